// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package subtractor_pkg;

    localparam int unsigned DEFAULT_SIZE = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: {bo, diff} = x - y - bi.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // Difference bit and borrow-out of a single column
    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {bout, d} = a - b - bin over SIZE shift cycles,
// using a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] d,
    output logic            bout
);

    localparam int unsigned     CW   = $clog2(SIZE);
    localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

    state_t          r_state;
    state_t          w_next;
    logic [SIZE-1:0] r_ra;
    logic [SIZE-1:0] r_rb;
    logic [SIZE-1:0] r_rd;
    logic            r_brw;
    logic [CW-1:0]   r_cnt;
    logic            w_x;
    logic            w_bo;
    logic            w_accept;
    logic            w_last;

    full_subtractor_1bit u_cell (
        .x    (r_ra[0]),
        .y    (r_rb[0]),
        .bi   (r_brw),
        .diff (w_x),
        .bo   (w_bo)
    );

    // busy and done are decoded straight from the state register, so they stay registered
    assign busy     = (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; DONE accepts a new request just like IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand load, serial shift, and result capture on the final shift edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_rd  <= '0;
            r_brw <= 1'b0;
            r_cnt <= '0;
            d     <= '0;
            bout  <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= a;
            r_rb  <= b;
            r_brw <= bin;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_ra  <= {1'b0, r_ra[SIZE-1:1]};
            r_rb  <= {1'b0, r_rb[SIZE-1:1]};
            r_rd  <= {w_x, r_rd[SIZE-1:1]};
            r_brw <= w_bo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                d    <= {w_x, r_rd[SIZE-1:1]};
                bout <= w_bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at SIZE=8 and SIZE=16 with a scoreboard queue.
module tb_serial_subtractor;

    typedef struct {
        logic [16:0] exp;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, d8;
    logic        start16, bin16, busy16, done16, bout16;
    logic [15:0] a16, b16, d16;

    int unsigned cyc = 0;
    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    exp_t        q8[$];
    exp_t        q16[$];
    exp_t        e8, e16;
    logic [16:0] last8, last16;
    int unsigned run8, run16;

    serial_subtractor #(.SIZE(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_subtractor #(.SIZE(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16), .bout(bout16)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // SIZE=8 monitor: compares results, latency, busy length and output hold
    always @(posedge clk) begin
        #1;
        if (reset) begin
            q8.delete();
            run8  = 0;
            last8 = '0;
        end else begin
            if (busy8) begin
                run8++;
                check("hold8", {23'd0, bout8, d8}, {15'd0, last8});
            end
            if (done8) begin
                check("busy_len8", run8, 8);
                run8 = 0;
                if (q8.size() == 0) begin
                    check("spurious_done8", {31'd0, done8}, 0);
                end else begin
                    e8 = q8.pop_front();
                    check("diff8", {23'd0, bout8, d8}, {15'd0, e8.exp});
                    check("latency8", cyc - e8.acc, 8);
                    last8 = e8.exp;
                end
            end
        end
    end

    // SIZE=16 monitor
    always @(posedge clk) begin
        #1;
        if (reset) begin
            q16.delete();
            run16  = 0;
            last16 = '0;
        end else begin
            if (busy16) begin
                run16++;
                check("hold16", {15'd0, bout16, d16}, {15'd0, last16});
            end
            if (done16) begin
                check("busy_len16", run16, 16);
                run16 = 0;
                if (q16.size() == 0) begin
                    check("spurious_done16", {31'd0, done16}, 0);
                end else begin
                    e16 = q16.pop_front();
                    check("diff16", {15'd0, bout16, d16}, {15'd0, e16.exp});
                    check("latency16", cyc - e16.acc, 16);
                    last16 = e16.exp;
                end
            end
        end
    end

    // Present one request once the selected DUT is not shifting; push its expected result
    task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input bit hold);
        int unsigned n = 0;
        exp_t        e;
        logic [8:0]  t9;
        @(negedge clk);
        while ((w ? busy16 : busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("timeout_idle", {31'd0, (w ? busy16 : busy8)}, 0);
        if (w) begin
            a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
            e.exp = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; bin8 = bi; start8 = 1'b1;
            t9 = {1'b0, a[7:0]} - {1'b0, b[7:0]} - {8'd0, bi};
            e.exp = {8'd0, t9};
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (w) q16.push_back(e);
        else   q8.push_back(e);
        if (!hold) begin
            if (w) start16 = 1'b0;
            else   start8  = 1'b0;
        end
    endtask

    // Release start and wait for all outstanding results to be compared
    task automatic drain(input bit w);
        int unsigned n = 0;
        if (w) start16 = 1'b0;
        else   start8  = 1'b0;
        while ((w ? q16.size() : q8.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", w ? q16.size() : q8.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out8", {21'd0, busy8, done8, bout8, d8}, 0);
        check("reset_out16", {13'd0, busy16, done16, bout16, d16}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed corner cases
        issue(0, 16'h5A, 16'h3C, 1'b0, 0); drain(0);
        issue(0, 16'h00, 16'h01, 1'b0, 0); drain(0);
        issue(0, 16'h80, 16'h80, 1'b1, 0); drain(0);
        issue(0, 16'hFF, 16'h00, 1'b1, 0); drain(0);

        // Operand changes and start pulses during SHIFT must not disturb the operation
        issue(0, 16'h10, 16'h01, 1'b0, 0);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'hAA; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain(0);
        repeat (12) @(posedge clk);

        // Reset on the 4th shift edge aborts without a done pulse
        issue(0, 16'h77, 16'h12, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("abort_out8", {21'd0, busy8, done8, bout8, d8}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        issue(0, 16'h03, 16'h05, 1'b0, 0); drain(0);

        // Back-to-back with start held through DONE
        issue(0, 16'hC3, 16'h5A, 1'b0, 1);
        issue(0, 16'h01, 16'h02, 1'b1, 0);
        drain(0);

        // Random back-to-back stream, SIZE=8
        for (int i = 0; i < 1000; i++)
            issue(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), i != 999);
        drain(0);

        // SIZE=16: corners then random stream
        issue(1, 16'h0000, 16'h0001, 1'b0, 0); drain(1);
        issue(1, 16'hFFFF, 16'h0000, 1'b1, 0); drain(1);
        issue(1, 16'h8000, 16'h8000, 1'b1, 0); drain(1);
        for (int i = 0; i < 200; i++)
            issue(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), i != 199);
        drain(1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
